// File: rtl/sprite_pkg.sv
// Shared sprite geometry, row/address types and loader state encoding.
package sprite_pkg;
  localparam int SPRITE_ROWS = 16;
  localparam int SPRITE_COLS = 32;
  localparam int SPRITE_BPR  = SPRITE_COLS / 8;

  typedef logic [SPRITE_COLS-1:0]         row_t;
  typedef logic [$clog2(SPRITE_ROWS)-1:0] raddr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } ld_state_t;
endpackage

// File: rtl/sprite_row_ram.sv
// ROWS x COLS sprite row store: synchronous write, asynchronous read.
// Reads outside the populated rows return zero.
module sprite_row_ram #(
  parameter int ROWS = 16,
  parameter int COLS = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] waddr,
  input  logic [COLS-1:0]         wdata,
  input  logic [$clog2(ROWS)-1:0] raddr,
  output logic [COLS-1:0]         rdata
);
  logic [COLS-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < ROWS) rdata = mem[raddr];
  end
endmodule

// File: rtl/sprite_ram_loader.sv
// Byte-stream sprite loader: packs bytes MSB-first into rows and exposes the renderer read port.
// Optional double buffering with frame-synchronous swap under macro SPRITE_DBUF_EN.
//
// state  | meaning
// IDLE   | waiting for a sof byte; non-sof bytes are dropped and flag err
// LOAD   | collecting rows 0..ROWS-1
// COMMIT | sprite complete; single bank: one cycle, double bank: wait for frame_start
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int ROWS = SPRITE_ROWS,
  parameter int COLS = SPRITE_COLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic                    in_ready,
  input  logic                    frame_start,
  input  logic [$clog2(ROWS)-1:0] rd_addr,
  output logic [COLS-1:0]         rd_data,
  output logic                    load_done,
  output logic                    busy,
  output logic                    err
);
  localparam int AW  = $clog2(ROWS);
  localparam int BPR = COLS / 8;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPR - 1);

  ld_state_t state, state_nxt;

  logic [AW-1:0]   row_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [COLS-9:0] shreg;
  logic            rst_done;

  logic            accept;
  logic            in_ctx;
  logic [AW-1:0]   eff_row;
  logic [BW-1:0]   eff_byte;
  logic [COLS-1:0] row_word;
  logic            wr_en;
  logic            last_accept;

  assign accept      = in_valid & in_ready;
  // A sof byte always starts row 0 byte 0, whether it arrives in IDLE or aborts a load.
  assign in_ctx      = in_sof | (state == LOAD);
  assign eff_row     = in_sof ? '0 : row_cnt;
  assign eff_byte    = in_sof ? '0 : byte_cnt;
  assign row_word    = {shreg, in_data};
  assign wr_en       = accept & in_ctx & (eff_byte == LAST_BYTE);
  assign last_accept = wr_en & (eff_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && in_sof) state_nxt = last_accept ? COMMIT : LOAD;
      LOAD:   if (last_accept)      state_nxt = COMMIT;
`ifdef SPRITE_DBUF_EN
      COMMIT: if (frame_start)      state_nxt = IDLE;
`else
      COMMIT:                       state_nxt = IDLE;
`endif
      default:                      state_nxt = IDLE;
    endcase
  end

`ifdef SPRITE_DBUF_EN
  logic load_done_q;
`endif

  always_comb begin
    in_ready  = rst_done & (state != COMMIT);
    busy      = (state != IDLE);
`ifdef SPRITE_DBUF_EN
    load_done = load_done_q;
`else
    load_done = (state == COMMIT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      err      <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        if (in_sof)              err <= 1'b0;
        else if (state == IDLE)  err <= 1'b1;
      end
      if (accept && in_ctx) begin
        shreg <= row_word[COLS-9:0];
        if (eff_byte == LAST_BYTE) begin
          byte_cnt <= '0;
          row_cnt  <= (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
        end else begin
          byte_cnt <= eff_byte + 1'b1;
          row_cnt  <= eff_row;
        end
      end
    end
  end

`ifdef SPRITE_DBUF_EN
  logic            bank_sel;
  logic [COLS-1:0] rd_data0, rd_data1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= (state == COMMIT) && frame_start;
      if ((state == COMMIT) && frame_start) bank_sel <= ~bank_sel;
    end
  end

  // Writes target the back bank, the renderer always reads the front bank.
  sprite_row_ram #(.ROWS(ROWS), .COLS(COLS)) u_bank0 (
    .clk   (clk),
    .we    (wr_en & bank_sel),
    .waddr (eff_row),
    .wdata (row_word),
    .raddr (rd_addr),
    .rdata (rd_data0)
  );

  sprite_row_ram #(.ROWS(ROWS), .COLS(COLS)) u_bank1 (
    .clk   (clk),
    .we    (wr_en & ~bank_sel),
    .waddr (eff_row),
    .wdata (row_word),
    .raddr (rd_addr),
    .rdata (rd_data1)
  );

  assign rd_data = bank_sel ? rd_data1 : rd_data0;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  sprite_row_ram #(.ROWS(ROWS), .COLS(COLS)) u_bank0 (
    .clk   (clk),
    .we    (wr_en),
    .waddr (eff_row),
    .wdata (row_word),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
`endif
endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader against a byte-position reference model.
// Honours SPRITE_DBUF_EN the same way the design does.
module tb_sprite_ram_loader;
  localparam int ROWS = 16;
  localparam int COLS = 32;
  localparam int NBYTES = ROWS * COLS / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_ready;
  logic        frame_start = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        load_done;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int ready_drops = 0;

  // Reference model: sprite byte position, pending row bytes, two row banks.
  logic [31:0] model_mem [2][ROWS];
  logic [7:0]  pend_q [$];
  bit          loading = 0;
  int          pos = 0;
  bit          model_err = 0;
  int          front = 0;

  sprite_ram_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .load_done   (load_done),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && load_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int write_bank();
`ifdef SPRITE_DBUF_EN
    return 1 - front;
`else
    return front;
`endif
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic s);
    if (s) begin
      loading = 1; pos = 0; model_err = 0; pend_q.delete();
    end else if (!loading) begin
      model_err = 1;
      return;
    end
    pend_q.push_back(d);
    if (pend_q.size() == COLS / 8) begin
      model_mem[write_bank()][pos / (COLS / 8)] = {pend_q[0], pend_q[1], pend_q[2], pend_q[3]};
      pend_q.delete();
    end
    pos++;
    if (pos == NBYTES) begin
      loading = 0;
`ifndef SPRITE_DBUF_EN
      exp_done++;
`endif
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    if (!in_ready) ready_drops++;
    in_data = d; in_sof = s; in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        check("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_accept(d, s);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // Finish a completed load: a no-op in single-bank builds, a held commit plus swap otherwise.
  task automatic finish_load();
`ifdef SPRITE_DBUF_EN
    repeat (3) @(negedge clk);
    check("commit_holds_ready", 32'(in_ready), 32'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    front = 1 - front;
    exp_done++;
    check("done_after_swap", 32'(load_done), 32'd1);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      rd_addr = 4'(r);
      #1;
      check(tag, rd_data, model_mem[front][r]);
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_done",  32'(load_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Incrementing stream, back-to-back
    for (int i = 0; i < NBYTES; i++) send(8'(i), i == 0, 0);
    finish_load();
    rd_addr = 4'd0;  #1; check("row0_const", rd_data, 32'h00010203);
    rd_addr = 4'd15; #1; check("row15_const", rd_data, 32'h3C3D3E3F);
    check_mem("t1_row");
    check("t1_done", 32'(done_cnt), 32'(exp_done));

    // Random data then the incrementing stream, both with random stalls
    for (int k = 0; k < 2; k++) begin
      ready_drops = 0;
      for (int i = 0; i < NBYTES; i++)
        send((k == 0) ? 8'($urandom) : 8'(i), i == 0, 1);
      check("t2_ready_drops", 32'(ready_drops), 32'd0);
      finish_load();
      check_mem("t2_row");
    end
    rd_addr = 4'd15; #1; check("t2_row15_const", rd_data, 32'h3C3D3E3F);
    check("t2_done", 32'(done_cnt), 32'(exp_done));

    // Stray bytes in IDLE
    for (int i = 0; i < 3; i++) send(8'hAA, 0, 0);
    check("t3_err_set", 32'(err), 32'(model_err));
    check("t3_err_one", 32'(err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check_mem("t3_nowrite");
    send(8'h5A, 1, 0);
    check("t3_err_clr", 32'(err), 32'd0);

    // Aborted loads followed by a full 0x11 sprite
    for (int i = 0; i < 10; i++) send(8'hFF, i == 0, 0);
    for (int i = 0; i < NBYTES; i++) send(8'h11, i == 0, $urandom_range(0, 1) == 1);
    finish_load();
    check_mem("t4_row");
    rd_addr = 4'd7; #1; check("t4_row7_const", rd_data, 32'h11111111);
    check("t4_done", 32'(done_cnt), 32'(exp_done));

`ifdef SPRITE_DBUF_EN
    // Back-bank load must stay invisible until frame_start
    for (int i = 0; i < NBYTES; i++) send(8'h00, i == 0, 0);
    finish_load();
    for (int i = 0; i < NBYTES; i++) send(8'hFF, i == 0, 0);
    repeat (5) @(negedge clk);
    rd_addr = 4'd3; #1;
    check("t5_hold_data", rd_data, 32'h00000000);
    check("t5_hold_ready", 32'(in_ready), 32'd0);
    check("t5_hold_busy", 32'(busy), 32'd1);
    finish_load();
    rd_addr = 4'd3; #1;
    check("t5_swapped", rd_data, 32'hFFFFFFFF);
    check_mem("t5_row");
`endif

    // Reset in the middle of a load
    for (int i = 0; i < 20; i++) send(8'($urandom), i == 0, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    loading = 0; pos = 0; pend_q.delete(); model_err = 0; front = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", 32'(in_ready), 32'd1);
    check("t6_rel_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NBYTES; i++) send(8'($urandom), i == 0, 1);
    finish_load();
    check_mem("t6_row");
    check("t6_done", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
